fft_out_serializer: RTL

Output unloader for the 64-point FFT pipeline. It captures each 2048-bit result frame that the pipeline presents in parallel and streams it out as 64 32-bit words over a valid/ready interface, one word per handshake. The pipeline emits results in bit-reversed order, so the block can optionally reorder the stream into natural order. Two frame buffers (ping-pong) let a new frame be captured while the previous one is still streaming.

---
 rtl/fft_out_serializer_if.sv | 28 ++
 rtl/fft_out_serializer.sv | 105 ++++++++++
 2 files changed

// File: rtl/fft_out_serializer_if.sv
// Word stream from the FFT output serializer: one word per valid/ready handshake,
// tagged with its natural-order index and an end-of-frame marker.
interface fft_out_serializer_if #(
    parameter int WORD_W = 32,
    parameter int IDX_W  = 6
);
    logic [WORD_W-1:0] m_data;
    logic [IDX_W-1:0]  m_index;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output m_data,
        output m_index,
        output m_last,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_index,
        input  m_last,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/fft_out_serializer.sv
// Ping-pong capture of parallel FFT result frames, streamed out one word per
// handshake in natural (bit-reversal undone) or raw slot order.
module fft_out_serializer #(
    parameter int N_POINTS = 64,
    parameter int WORD_W   = 32,
    parameter int IDX_W    = 6,
    parameter bit BITREV   = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_POINTS*WORD_W-1:0] frame_in,
    input  logic                       frame_valid,
    fft_out_serializer_if.master       stream,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic                       busy
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

    logic [N_POINTS*WORD_W-1:0] frame_buf_reg [2];
    logic [N_POINTS*WORD_W-1:0] rd_frame;
    logic [WORD_W-1:0]          slot_words [N_POINTS];
    logic [1:0]                 full_reg;
    logic [1:0]                 full_next;
    logic                       wr_sel_reg;
    logic                       rd_sel_reg;
    logic [IDX_W-1:0]           cnt_reg;
    logic                       overflow_reg;
    logic [IDX_W-1:0]           rev_idx;
    logic [IDX_W-1:0]           slot_idx;
    logic                       xfer;
    logic                       last_xfer;
    logic                       wr_free;
    logic                       capture;
    logic                       drop;

    generate
        for (genvar gi = 0; gi < IDX_W; gi++) begin : g_rev
            assign rev_idx[gi] = cnt_reg[IDX_W-1-gi];
        end
    endgenerate

    assign slot_idx = BITREV ? rev_idx : cnt_reg;
    assign rd_frame = frame_buf_reg[rd_sel_reg];

    generate
        for (genvar gi = 0; gi < N_POINTS; gi++) begin : g_slot
            assign slot_words[gi] = rd_frame[WORD_W*gi +: WORD_W];
        end
    endgenerate

    assign xfer      = full_reg[rd_sel_reg] & stream.m_ready;
    assign last_xfer = xfer & (cnt_reg == LAST_IDX);

    // A buffer whose last word leaves this cycle can take a new frame in the same edge.
    assign wr_free = !full_reg[wr_sel_reg] | (last_xfer & (rd_sel_reg == wr_sel_reg));
    assign capture = frame_valid & wr_free;
    assign drop    = frame_valid & !wr_free;

    always_comb begin
        full_next = full_reg;
        if (last_xfer) begin
            full_next[rd_sel_reg] = 1'b0;
        end
        if (capture) begin
            full_next[wr_sel_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_buf_reg[0] <= '0;
            frame_buf_reg[1] <= '0;
            full_reg         <= '0;
            wr_sel_reg       <= 1'b0;
            rd_sel_reg       <= 1'b0;
            cnt_reg          <= '0;
            overflow_reg     <= 1'b0;
        end else begin
            full_reg <= full_next;
            if (capture) begin
                frame_buf_reg[wr_sel_reg] <= frame_in;
                wr_sel_reg                <= !wr_sel_reg;
            end
            if (last_xfer) begin
                cnt_reg    <= '0;
                rd_sel_reg <= !rd_sel_reg;
            end else if (xfer) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign stream.m_valid = full_reg[rd_sel_reg];
    assign stream.m_data  = slot_words[slot_idx];
    assign stream.m_index = cnt_reg;
    assign stream.m_last  = full_reg[rd_sel_reg] & (cnt_reg == LAST_IDX);
    assign overflow       = overflow_reg;
    assign busy           = full_reg[0] | full_reg[1];
endmodule
